// File: rtl/accum_16bit.sv
// accum_16bit: frame accumulator around a ripple-carry adder, result on a valid/ready port
module rc_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] s,
   output logic        cout
);
   logic [16:0] c;
   assign c[0] = cin;
   for (genvar i = 0; i < 16; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign cout = c[16];
endmodule

module accum_16bit #(
   parameter int N = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] din,
   input  logic        last,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] sum,
   output logic [7:0]  carries,
   output logic [7:0]  nwords,
   output logic        out_valid,
   input  logic        out_ready
);
   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
   state_t      state_q, state_d;
   logic [15:0] acc_q, acc_d, sum_q, sum_d, s;
   logic [7:0]  car_q, car_d, cnt_q, cnt_d, nw_q, nw_d;
   logic        cout, acc_en, fin, clr;
   rc_16bit u_add (.a(acc_q), .b(din), .cin(1'b0), .s(s), .cout(cout));
   assign in_ready  = state_q == ACC;
   assign out_valid = state_q == DONE;
   assign sum       = sum_q;
   assign carries   = car_q;
   assign nwords    = nw_q;
   always_comb begin
      acc_en  = in_valid && state_q == ACC;
      fin     = acc_en && (last || cnt_q + 8'd1 == 8'(N));
      clr     = state_q == DONE && out_ready;
      state_d = state_q == IDLE ? ACC : fin ? DONE : clr ? ACC : state_q;
      acc_d   = clr ? '0 : acc_en ? s : acc_q;
      car_d   = clr ? '0 : acc_en && car_q != 8'hFF ? car_q + {7'd0, cout} : car_q;
      cnt_d   = clr ? '0 : acc_en ? cnt_q + 8'd1 : cnt_q;
      nw_d    = fin ? cnt_q + 8'd1 : nw_q;
      sum_d   = fin ? s : sum_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         sum_q   <= '0;
         car_q   <= '0;
         cnt_q   <= '0;
         nw_q    <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         car_q   <= car_d;
         cnt_q   <= cnt_d;
         nw_q    <= nw_d;
      end
   end
endmodule

// File: doc/accum_16bit.md
# accum_16bit

Frame accumulator sitting directly downstream of the 16-bit ripple-carry adder `rc_16bit`. It sums a frame of up to N 16-bit words with one internal `rc_16bit` instance (cin tied 0), with the accumulator register fed back as operand `a` and the input word as operand `b`. It counts carry-outs, then presents the frame result on a valid/ready output port. It turns the combinational adder into a streaming, back-pressured reduction stage.

## Interface
- N, default 4: maximum words per frame; legal range 1..255.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  reset; one clock, synchronous, active-low.
- din  input  16  input word.
- last  input  1  marks the final word of a frame; valid only with in_valid.
- in_valid  input  1  din/last valid.
- in_ready  output  1  block accepts a word this cycle.
- sum  output  16  frame sum modulo 2^16.
- carries  output  8  number of adder cout=1 events in the frame.
- nwords  output  8  words accepted in the frame, 1..N.
- out_valid  output  1  sum/carries/nwords valid.
- out_ready  input  1  downstream consumes the result.

## Operation
- States: IDLE, ACC, DONE. All registers update on the rising edge of clk.
- Reset: rst_n low at an edge forces the following values regardless of other inputs, and discards any partial frame or held result:
  - state=IDLE
  - acc=0, carries=0, cnt=0
  - out_valid=0
- Register reset values: sum=0x0000, carries=0, nwords=0. in_ready=0 while in IDLE.
- IDLE: in_ready=0 and out_valid=0. Unconditional transition to ACC on the next edge.
- ACC: in_ready=1 and out_valid=0. A word is accepted on an edge when in_valid && in_ready.
- On accept:
  - acc <= s, where s is the rc_16bit sum of (acc, din, 0).
  - carries <= carries + cout. carries saturates at 255.
  - cnt <= cnt + 1.
- Frame end: the accepted word has last=1, or cnt+1 == N. On that same edge the accumulate above still happens, nwords <= cnt+1, and state goes to DONE.
- DONE:
  - in_ready=0, out_valid=1.
  - sum, carries and nwords are stable and driven from registers.
  - din, in_valid and last are ignored.
  - On an edge with out_ready=1: state goes to ACC; acc, carries and cnt clear to 0. nwords and sum keep their last values but are not valid.
- Arithmetic: unsigned, 16-bit wrap. sum = low 16 bits of the total; carries = number of wraps.
- last=1 on the first word gives a frame with nwords=1 and sum=din.
- No word is accepted in the DONE→ACC handoff cycle. in_ready rises the cycle after the result is taken.

## Timing
- After rst_n deasserts: the first edge goes IDLE→ACC, so in_ready=1 from the second cycle.
- Accumulate latency: one cycle per accepted word. No added pipeline stage; the adder path is a single combinational rc_16bit path.
- out_valid asserts the cycle after the edge that accepts the frame-ending word.
- Minimum frame period: nwords+1 cycles when in_valid and out_ready are held high.
- Gaps in in_valid stall accumulation with no state change.
- out_ready low holds DONE and all outputs indefinitely.
- sum and out_valid are registered outputs. in_ready is decoded from the state register only, with no combinational path from any input.

## Test plan
- N=4 basic frame; words 0x001F, 0x000C, 0x0001, 0x0002 with last=0, out_ready=1:
  - out_valid asserts on the cycle after the 4th accept.
  - sum=0x002E, carries=0, nwords=4.
- N=4 carry counting; words 0xFFFF, 0x0001, 0xFFFF, 0x0001 -> sum=0x0000, carries=2, nwords=4.
- Early last; word 0xC61F with last=0, then 0x018C with last=1 -> sum=0xC7AB, carries=0, nwords=2.
- Back-pressure after a frame; hold out_ready=0 for 5 cycles with in_valid=1 and din=0x1234:
  - out_valid stays 1, outputs are unchanged, in_ready=0, and no word is consumed.
  - Raise out_ready: in_ready=1 two cycles later (handoff cycle, then ACC). The next frame starts from acc=0.
- Reset mid-frame; accept 0x00FF and 0x0F00, then pulse rst_n low for 1 cycle:
  - out_valid=0, sum=0, in_ready=0 during IDLE.
  - A following 4-word frame of 0x0001 yields sum=0x0004 and nwords=4.
- Gapped input; N=4 words 0x0010 ×4 with 2 idle cycles between each -> sum=0x0040, carries=0, nwords=4. No extra accumulate occurs in the idle cycles.
